mac_accum_drain: RTL and testbench

- Downstream companion of the 2x2 SIMD multiply/ALU overlay.
- Tracks which products are valid as they move through the multiplier/ALU pipeline, and drives the overlay's X (`result_2`) feedback so S accumulates across a dot-product group.
- Captures each finished group result (S plus per-lane sticky carry) into a small output FIFO with a valid/ready handshake.
- Issues credit-based `issue_ready` back to the operand feeder so no finished result is ever lost.

---
 rtl/mac_accum_drain.sv | 197 +++++++++++++++++++
 tb/tb_mac_accum_drain.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_drain.sv
// mac_accum_drain
//
// Downstream companion of the 2x2 SIMD multiply/ALU overlay. It tracks the
// valid/last flags of issued terms through the multiplier pipeline. It drives
// the overlay's X operand so that S accumulates across a dot-product group.
// Each finished group (S, per-lane sticky carry, term count) is captured into a
// small output FIFO. The block also issues credits back to the operand feeder.
//
// Handshakes:
//   out_valid/out_ready : the head entry moves when out_valid & out_ready are
//                         both high on a rising edge. out_valid does not depend
//                         on out_ready.
//   issue_ready         : credit for a term that carries issue_last. Non-last
//                         terms are always accepted. It is computed from
//                         registered state only.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mode[1:0]           SIMD mode (00 1x32, 01 2x16, 1x 4x8)
//   issue_valid/last    term presented to the overlay this cycle / final term
//   issue_ready         feeder may issue a last term
//   s_in[31:0]          overlay S register
//   carry_in[3:0]       overlay per-lane carry-out register
//   result_2[31:0]      X operand to the overlay ALU
//   out_data/ovf/count  FIFO head: group sum, sticky lane carries, term count
//   out_valid/out_ready FIFO head handshake
//   err_drop            sticky: a finished result hit a full FIFO and was lost
module mac_accum_drain #(
    parameter int MULT_LAT = 2,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             issue_valid,
    input  logic             issue_last,
    output logic             issue_ready,
    input  logic [31:0]      s_in,
    input  logic [3:0]       carry_in,
    output logic [31:0]      result_2,
    output logic [31:0]      out_data,
    output logic [3:0]       out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + 4 + CNT_W;

    // Term tracking: delay line tail is the ALU stage, s_* is one stage later
    logic [MULT_LAT-1:0] dl_v, dl_l;
    logic                alu_v, alu_l;
    logic                s_v, s_l;

    // Group state
    logic             first;
    logic [1:0]       lmode;
    logic [31:0]      acc;
    logic [3:0]       ovf;
    logic [CNT_W-1:0] cnt;
    logic             drop_flag;

    // Output FIFO
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;

    logic [3:0]       lane_mask;
    logic [3:0]       ovf_next;
    logic [CNT_W-1:0] cnt_next;
    logic             push, pop, full, fifo_write, drop;
    logic [31:0]      inflight;
    logic [31:0]      credit_use;

    assign alu_v = dl_v[MULT_LAT-1];
    assign alu_l = dl_l[MULT_LAT-1];

    always_comb begin
        lane_mask = 4'b1111;
        case (lmode)
            2'b00:   lane_mask = 4'b1000;
            2'b01:   lane_mask = 4'b1010;
            default: lane_mask = 4'b1111;
        endcase
    end

    assign ovf_next = ovf | (carry_in & lane_mask);
    assign cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // X feedback: zero on a group's first term. Otherwise the newest S wins.
    // When a term finishes in the S stage this cycle, acc is one cycle stale,
    // so s_in is forwarded directly.
    always_comb begin
        result_2 = acc;
        if (alu_v && first) begin
            result_2 = '0;
        end else if (s_v) begin
            result_2 = s_in;
        end
    end

    assign push       = s_v & s_l;
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid & out_ready;
    assign full       = (fifo_count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign fifo_write = push & (~full | pop);
    assign drop       = push & full & ~pop;

    // Every last-flag still in flight will need one FIFO slot
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MULT_LAT; i++) begin
            inflight = inflight + {31'd0, dl_v[i] & dl_l[i]};
        end
        inflight = inflight + {31'd0, push};
    end

    assign credit_use  = 32'(fifo_count) + inflight;
    assign issue_ready = (credit_use < 32'(DEPTH));

    assign out_data  = mem[rd_ptr][EW-1 -: 32];
    assign out_ovf   = mem[rd_ptr][CNT_W +: 4];
    assign out_count = mem[rd_ptr][CNT_W-1:0];
    assign err_drop  = drop_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_v       <= '0;
            dl_l       <= '0;
            s_v        <= 1'b0;
            s_l        <= 1'b0;
            first      <= 1'b1;
            lmode      <= '0;
            acc        <= '0;
            ovf        <= '0;
            cnt        <= '0;
            drop_flag  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            dl_v[0] <= issue_valid;
            dl_l[0] <= issue_valid & issue_last;
            for (int i = 1; i < MULT_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_l[i] <= dl_l[i-1];
            end
            s_v <= alu_v;
            s_l <= alu_l;

            // A single-term group clears and sets first in one step, so it stays 1
            if (alu_v) begin
                first <= alu_l;
            end
            if (alu_v && first) begin
                lmode <= mode;
            end

            if (s_v) begin
                acc <= s_in;
            end

            if (push) begin
                ovf <= '0;
                cnt <= '0;
            end else if (s_v) begin
                ovf <= ovf_next;
                cnt <= cnt_next;
            end

            if (fifo_write) begin
                mem[wr_ptr] <= {s_in, ovf_next, cnt_next};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (fifo_write && !pop) begin
                fifo_count <= fifo_count + (AW+1)'(1);
            end else if (!fifo_write && pop) begin
                fifo_count <= fifo_count - (AW+1)'(1);
            end

            if (drop) begin
                drop_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_drain.sv
// Testbench for mac_accum_drain. It contains a small overlay model (S = X + P,
// one cycle after the ALU stage) and a group-level reference model. Expected
// results are whole-group sums, OR-ed lane carries and term counts, held in an
// expected queue that mirrors the output FIFO.
module tb_mac_accum_drain;

    localparam int ML    = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic             issue_valid, issue_last, issue_ready;
    logic [31:0]      s_in;
    logic [3:0]       carry_in;
    logic [31:0]      result_2;
    logic [31:0]      out_data;
    logic [3:0]       out_ovf;
    logic [CNT_W-1:0] out_count;
    logic             out_valid, out_ready;
    logic             err_drop;

    always #5 clk = ~clk;

    mac_accum_drain #(.MULT_LAT(ML), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .issue_valid(issue_valid), .issue_last(issue_last), .issue_ready(issue_ready),
        .s_in(s_in), .carry_in(carry_in), .result_2(result_2),
        .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready), .err_drop(err_drop)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Terms travelling toward the ALU stage: valid, product, carry, expected X
    logic        pv [ML];
    logic [31:0] pp [ML];
    logic [31:0] px [ML];
    logic [3:0]  pc [ML];

    logic [31:0] cur_prod;
    logic [3:0]  cur_carry;

    // Open group being issued
    int          grp_cnt;
    int          grp_first;
    logic [31:0] grp_sum;
    logic [3:0]  grp_cor;

    typedef struct {
        int          cyc;
        int          first;
        logic [31:0] sum;
        logic [3:0]  cor;
        int          cnt;
    } pend_t;

    pend_t       pend_q[$];
    logic [51:0] exp_q[$];
    logic        exp_err;
    logic [31:0] last_alu_sum;
    logic [1:0]  mode_hist [int];

    function automatic logic [3:0] lane_mask(input logic [1:0] m);
        if (m == 2'b00) return 4'b1000;
        if (m == 2'b01) return 4'b1010;
        return 4'b1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ML; i++) begin
            pv[i] = 1'b0;
            pp[i] = '0;
            px[i] = '0;
            pc[i] = '0;
        end
        grp_cnt      = 0;
        grp_first    = 0;
        grp_sum      = '0;
        grp_cor      = '0;
        exp_err      = 1'b0;
        last_alu_sum = '0;
        pend_q.delete();
        exp_q.delete();
    endtask

    // One clock cycle. Called at a negedge with the inputs already driven.
    task automatic tick();
        logic [31:0] s_next;
        logic [3:0]  c_next;
        logic        pop;
        logic        full_before;
        logic [51:0] head;
        pend_t       pe;

        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk("out_data", out_data, head[51:20]);
            chk("out_ovf", out_ovf, head[19:16]);
            chk("out_count", out_count, head[15:0]);
        end
        chk("issue_ready", issue_ready, (exp_q.size() + pend_q.size()) < DEPTH);
        chk("err_drop", err_drop, exp_err);
        if (pv[ML-1]) chk("result_2_term", result_2, px[ML-1]);
        else          chk("result_2_idle", result_2, last_alu_sum);

        // Overlay: S register takes X + product; garbage on bubbles
        if (pv[ML-1]) begin
            s_next       = result_2 + pp[ML-1];
            c_next       = pc[ML-1];
            last_alu_sum = px[ML-1] + pp[ML-1];
        end else begin
            s_next = $urandom;
            c_next = 4'($urandom_range(0, 15));
        end

        mode_hist[cyc] = mode;

        // Output FIFO at group granularity
        pop         = out_ready && (exp_q.size() > 0);
        full_before = (exp_q.size() == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
            pe = pend_q.pop_front();
            if (full_before && !pop) exp_err = 1'b1;
            else exp_q.push_back({pe.sum, pe.cor & lane_mask(mode_hist[pe.first + ML]), 16'(pe.cnt)});
        end

        // Issue side
        for (int i = ML - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pp[i] = pp[i-1];
            px[i] = px[i-1];
            pc[i] = pc[i-1];
        end
        pv[0] = issue_valid;
        pp[0] = cur_prod;
        pc[0] = cur_carry;
        px[0] = grp_sum;
        if (issue_valid) begin
            if (grp_cnt == 0) grp_first = cyc;
            grp_sum = grp_sum + cur_prod;
            grp_cor = grp_cor | cur_carry;
            grp_cnt++;
            if (issue_last) begin
                pend_q.push_back('{cyc + ML + 1, grp_first, grp_sum, grp_cor, grp_cnt});
                grp_cnt = 0;
                grp_sum = '0;
                grp_cor = '0;
            end
        end

        if (reset) model_clear();
        cyc++;

        @(posedge clk);
        #1;
        s_in     = s_next;
        carry_in = c_next;
        @(negedge clk);
    endtask

    task automatic term(input logic v, input logic l, input logic [31:0] p, input logic [3:0] c);
        issue_valid = v;
        issue_last  = l;
        cur_prod    = p;
        cur_carry   = c;
        tick();
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset       = 1'b1;
        mode        = 2'b00;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        out_ready   = 1'b1;
        s_in        = '0;
        carry_in    = '0;
        cur_prod    = '0;
        cur_carry   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_result_2", result_2, 32'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", out_ovf, 4'd0);
        chk("rst_out_count", out_count, 16'd0);
        chk("rst_err_drop", err_drop, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        reset = 1'b0;

        // Back-to-back group 3,5,7: X goes 0,3,8
        term(1, 0, 3, 0);
        term(1, 0, 5, 0);
        term(1, 1, 7, 0);
        idle(3);
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_data", out_data, 32'd15);
        chk("b2b_count", out_count, 16'd3);
        chk("b2b_ovf", out_ovf, 4'd0);
        idle(2);

        // Bubbles inside a group
        term(1, 0, 4, 0);
        idle(2);
        term(1, 1, 6, 0);
        idle(3);
        chk("bub_data", out_data, 32'd10);
        chk("bub_count", out_count, 16'd2);
        idle(2);

        // 2x16 lanes; mode change mid-group has no effect on the mask
        mode = 2'b01;
        term(1, 0, 100, 4'b0010);
        term(1, 0, 200, 4'b1000);
        idle(1);
        mode = 2'b10;
        term(1, 1, 300, 4'b0101);
        idle(3);
        chk("lane_ovf", out_ovf, 4'b1010);
        chk("lane_data", out_data, 32'd600);
        chk("lane_count", out_count, 16'd3);
        mode = 2'b00;
        idle(2);

        // Backpressure with two single-term groups
        out_ready = 1'b0;
        term(1, 1, 11, 0);
        term(1, 1, 22, 0);
        chk("bp_ready_low", issue_ready, 1'b0);
        idle(4);
        chk("bp_ready_full", issue_ready, 1'b0);
        chk("bp_err", err_drop, 1'b0);
        chk("bp_head0", out_data, 32'd11);
        out_ready = 1'b1;
        idle(1);
        chk("bp_head1", out_data, 32'd22);
        idle(1);
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_ready_back", issue_ready, 1'b1);

        // Forced overflow: third last issued while no credit
        out_ready = 1'b0;
        term(1, 1, 33, 0);
        term(1, 1, 44, 0);
        term(1, 1, 55, 0);
        idle(5);
        chk("ovf_err", err_drop, 1'b1);
        chk("ovf_head0", out_data, 32'd33);
        chk("ovf_count0", out_count, 16'd1);
        out_ready = 1'b1;
        idle(1);
        chk("ovf_head1", out_data, 32'd44);
        idle(1);
        chk("ovf_empty", out_valid, 1'b0);
        chk("ovf_err_sticky", err_drop, 1'b1);

        // Reset in the middle of a group
        term(1, 0, 9, 4'b1111);
        term(1, 0, 9, 4'b1111);
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        tick();
        reset = 1'b0;
        chk("mr_result_2", result_2, 32'd0);
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_out_data", out_data, 32'd0);
        chk("mr_out_ovf", out_ovf, 4'd0);
        chk("mr_out_count", out_count, 16'd0);
        chk("mr_err_drop", err_drop, 1'b0);
        term(1, 0, 2, 0);
        term(1, 1, 2, 0);
        idle(3);
        chk("mr_data", out_data, 32'd4);
        chk("mr_count", out_count, 16'd2);
        idle(2);

        // Random traffic that honours issue_ready
        for (int i = 0; i < 400; i++) begin
            mode        = 2'($urandom_range(0, 3));
            out_ready   = ($urandom_range(0, 3) != 0);
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_last  = issue_valid && ($urandom_range(0, 9) < 3) &&
                          ((exp_q.size() + pend_q.size()) < DEPTH);
            cur_prod    = $urandom;
            cur_carry   = 4'($urandom_range(0, 15));
            tick();
        end
        out_ready = 1'b1;
        idle(8);
        chk("final_empty", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
